// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: register offsets, CTRL layout and decode helper for apb_timer.
// Optional feature macro: APB_TIMER_PWM_EN (enables the DUTY register / PWM output).
package apb_timer_pkg;

  // Word offsets as seen on PADDR[4:2]
  localparam logic [2:0] CTRL_OFF   = 3'd0;  // 0x00
  localparam logic [2:0] PRESC_OFF  = 3'd1;  // 0x04
  localparam logic [2:0] CMP_OFF    = 3'd2;  // 0x08
  localparam logic [2:0] COUNT_OFF  = 3'd3;  // 0x0C
  localparam logic [2:0] STATUS_OFF = 3'd4;  // 0x10
  localparam logic [2:0] DUTY_OFF   = 3'd5;  // 0x14

  // CTRL bit positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_AR_BIT    = 1;
  localparam int CTRL_IRQEN_BIT = 2;

  typedef struct packed {
    logic irqen;
    logic autoreload;
    logic en;
  } ctrl_t;

  // True when the word offset hits an implemented register
  function automatic logic off_mapped(input logic [2:0] off);
`ifdef APB_TIMER_PWM_EN
    return (off <= DUTY_OFF);
`else
    return (off <= STATUS_OFF);
`endif
  endfunction

endpackage

// File: rtl/apb_timer_if.sv
// apb_timer_if: APB3 slave bus bundle for apb_timer (master/slave modports).
interface apb_timer_if #(parameter int APB_ADDR_WIDTH = 12);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_timer_prescaler.sv
// apb_timer_prescaler: 16-bit prescaler producing one tick every presc+1 enabled cycles.
module apb_timer_prescaler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        presc_wr,
  input  logic [15:0] presc,
  output logic        tick
);

  logic [15:0] pcnt_q, pcnt_d;

  assign tick = en & (pcnt_q == presc);

  // Next pcnt: restart on tick, when disabled, or when the divider is reprogrammed
  always_comb begin
    pcnt_d = pcnt_q + 16'd1;
    if (!en || presc_wr || tick) pcnt_d = '0;
  end

  // pcnt register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/apb_timer.sv
// apb_timer: zero-wait APB timer with prescaler, compare match, auto-reload,
// level interrupt and optional PWM output (macro APB_TIMER_PWM_EN).
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  apb_timer_if.slave  apb,
  output logic        irq_o,
  output logic        pwm_o
);

  // Bus decode
  logic [2:0] off;
  logic       setup, access, wr;
  logic       wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status;
  logic       unused_paddr;

  assign off       = apb.PADDR[4:2];
  assign setup     = apb.PSEL & ~apb.PENABLE;
  assign access    = apb.PSEL &  apb.PENABLE;
  assign wr        = access & apb.PWRITE & off_mapped(off);
  assign wr_ctrl   = wr & (off == CTRL_OFF);
  assign wr_presc  = wr & (off == PRESC_OFF);
  assign wr_cmp    = wr & (off == CMP_OFF);
  assign wr_count  = wr & (off == COUNT_OFF);
  assign wr_status = wr & (off == STATUS_OFF);
  assign unused_paddr = ^{apb.PADDR[APB_ADDR_WIDTH-1:5], apb.PADDR[1:0]};

  assign apb.PREADY = 1'b1;

  // Register state
  ctrl_t       ctrl_q, ctrl_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] count_q, count_d;
  logic        match_q, match_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pslverr_q, pslverr_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata;
  logic        tick;

  apb_timer_prescaler u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ctrl_q.en),
    .presc_wr (wr_presc),
    .presc    (presc_q),
    .tick     (tick)
  );

`ifdef APB_TIMER_PWM_EN
  logic [31:0] duty_q, duty_d;
  logic        pwm_q, pwm_d;
`endif

  // Read mux over current register state
  always_comb begin
    rdata = '0;
    case (off)
      CTRL_OFF:   rdata = {29'd0, ctrl_q};
      PRESC_OFF:  rdata = {16'd0, presc_q};
      CMP_OFF:    rdata = cmp_q;
      COUNT_OFF:  rdata = count_q;
      STATUS_OFF: rdata = {31'd0, match_q};
`ifdef APB_TIMER_PWM_EN
      DUTY_OFF:   rdata = duty_q;
`endif
      default:    rdata = '0;
    endcase
  end

  // Next-state: W1C first so a same-cycle match wins, timer update next,
  // then software writes so they override hardware COUNT/EN updates.
  always_comb begin
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    cmp_d     = cmp_q;
    count_d   = count_q;
    match_d   = match_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    irq_d     = match_q & ctrl_q.irqen;

    if (wr_status && apb.PWDATA[0]) match_d = 1'b0;

    if (tick) begin
      if (count_q == cmp_q) begin
        match_d = 1'b1;
        if (ctrl_q.autoreload) count_d   = '0;
        else                   ctrl_d.en = 1'b0;  // one-shot stop
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_ctrl) begin
      ctrl_d.en         = apb.PWDATA[CTRL_EN_BIT];
      ctrl_d.autoreload = apb.PWDATA[CTRL_AR_BIT];
      ctrl_d.irqen      = apb.PWDATA[CTRL_IRQEN_BIT];
    end
    if (wr_presc) presc_d = apb.PWDATA[15:0];
    if (wr_cmp)   cmp_d   = apb.PWDATA;
    if (wr_count) count_d = apb.PWDATA;

    if (setup) begin
      prdata_d  = rdata;
      pslverr_d = ~off_mapped(off);
    end
  end

  // Register file, counter and bus response flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      presc_q   <= '0;
      cmp_q     <= '0;
      count_q   <= '0;
      match_q   <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      cmp_q     <= cmp_d;
      count_q   <= count_d;
      match_q   <= match_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      irq_q     <= irq_d;
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PSLVERR = pslverr_q;
  assign irq_o       = irq_q;

`ifdef APB_TIMER_PWM_EN
  // DUTY write and PWM compare against the live count
  always_comb begin
    duty_d = duty_q;
    if (wr && (off == DUTY_OFF)) duty_d = apb.PWDATA;
    pwm_d = ctrl_q.en & (count_q < duty_q);
  end

  // DUTY and PWM output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;
`else
  assign pwm_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed self-checking bench for apb_timer.
// Honors APB_TIMER_PWM_EN the same way as the RTL.
module tb_apb_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq_o, pwm_o;
  int   checks = 0;
  int   errors = 0;

  apb_timer_if #(.APB_ADDR_WIDTH(12)) bus ();

  apb_timer #(.APB_ADDR_WIDTH(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .apb   (bus),
    .irq_o (irq_o),
    .pwm_o (pwm_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; setup edge follows, access edge after that; returns at a negedge.
  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, output logic err);
    bus.PADDR = a; bus.PWDATA = d; bus.PWRITE = 1'b1; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    err = bus.PSLVERR;
    @(negedge clk);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic err);
    bus.PADDR = a; bus.PWRITE = 1'b0; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    d   = bus.PRDATA;
    err = bus.PSLVERR;
    @(negedge clk);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic e;
    apb_wr(a, d, e);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_rd(a, d, e);
    check(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [29:0] pat;
    int          hi;

    bus.PADDR = '0; bus.PWDATA = '0; bus.PWRITE = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_irq",     irq_o, 0);
    check("rst_pwm",     pwm_o, 0);
    check("rst_prdata",  bus.PRDATA, 0);
    check("rst_pslverr", bus.PSLVERR, 0);
    check("rst_pready",  bus.PREADY, 1);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("rst_ctrl",   12'h000, 0);
    rd_chk("rst_presc",  12'h004, 0);
    rd_chk("rst_cmp",    12'h008, 0);
    rd_chk("rst_count",  12'h00C, 0);
    apb_rd(12'h010, d, e);
    check("rst_status", d, 0);
    check("rst_status_err", e, 0);
`ifdef APB_TIMER_PWM_EN
    rd_chk("rst_duty",   12'h014, 0);
`endif

    // Auto-reload, PRESC=0 CMP=4: match every 5 cycles, irq one later
    wr(12'h004, 0);
    wr(12'h008, 4);
    wr(12'h000, 32'h7);                       // lands on E0
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("ar_irq_low_%0d", k), irq_o, 0);
    end
    @(negedge clk);
    check("ar_irq_rise", irq_o, 1);          // N6
    wr(12'h010, 1);                          // W1C lands on E8
    check("ar_irq_hold_w1c_edge", irq_o, 1);
    @(negedge clk);
    check("ar_irq_drop", irq_o, 0);          // N9
    @(negedge clk);
    @(negedge clk);
    check("ar_irq_rerise", irq_o, 1);        // N11, match at E10
    wr(12'h000, 0);                          // stop on E13, count reaches 3
    rd_chk("ar_status_set", 12'h010, 1);
    rd_chk("ar_count_stop", 12'h00C, 3);
    wr(12'h010, 1);
    rd_chk("ar_status_clr", 12'h010, 0);
    check("ar_irq_after_clr", irq_o, 0);

    // One-shot, PRESC=3 CMP=2: match at cycle 12
    wr(12'h00C, 0);
    wr(12'h004, 3);
    wr(12'h008, 2);
    wr(12'h000, 32'h1);                      // E0
    repeat (11) @(negedge clk);
    rd_chk("os_status_early", 12'h010, 0);   // state after E11
    rd_chk("os_status_match", 12'h010, 1);   // state after E13
    rd_chk("os_ctrl_cleared", 12'h000, 0);
    rd_chk("os_count_hold",   12'h00C, 2);
    check("os_irq_masked", irq_o, 0);

    // Wrap: COUNT=FFFFFFFF, CMP=0x10, PRESC=0 -> match on 18th tick
    wr(12'h010, 1);
    wr(12'h00C, 32'hFFFF_FFFF);
    wr(12'h008, 32'h10);
    wr(12'h004, 0);
    wr(12'h000, 32'h1);                      // E0
    @(negedge clk);
    rd_chk("wrap_count_zero", 12'h00C, 0);   // after E1
    repeat (14) @(negedge clk);
    rd_chk("wrap_status_17", 12'h010, 0);    // after E17
    rd_chk("wrap_status_19", 12'h010, 1);
    rd_chk("wrap_count_hold", 12'h00C, 32'h10);

    // Unmapped offsets
    apb_wr(12'h01C, 32'hFFFF_FFFF, e);
    check("unmap_wr_err", e, 1);
    apb_rd(12'h01C, d, e);
    check("unmap_rd_data", d, 0);
    check("unmap_rd_err", e, 1);
    apb_rd(12'h008, d, e);
    check("unmap_cmp_kept", d, 32'h10);
    check("mapped_rd_err", e, 0);
    rd_chk("unmap_ctrl_kept", 12'h000, 0);
    rd_chk("unmap_presc_kept", 12'h004, 0);
    rd_chk("unmap_count_kept", 12'h00C, 32'h10);
`ifndef APB_TIMER_PWM_EN
    apb_wr(12'h014, 32'h5, e);
    check("duty_unmap_wr_err", e, 1);
    apb_rd(12'h014, d, e);
    check("duty_unmap_rd_data", d, 0);
    check("duty_unmap_rd_err", e, 1);
    check("pwm_tied_low", pwm_o, 0);
`else
    // PWM: CMP=9 DUTY=3 -> high 3 of every 10 cycles
    wr(12'h010, 1);
    wr(12'h00C, 0);
    wr(12'h008, 9);
    wr(12'h014, 3);
    wr(12'h004, 0);
    wr(12'h000, 32'h3);                      // E0
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      pat[k] = pwm_o;
    end
    check("pwm_pattern", {2'b00, pat}, 32'h0070_1C07);
    wr(12'h014, 0);
    rd_chk("pwm_duty_rd", 12'h014, 0);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      hi += int'(pwm_o);
    end
    check("pwm_duty0_const0", hi, 0);
    wr(12'h000, 0);
`endif

    // Asynchronous reset mid-operation
    wr(12'h00C, 0);
    wr(12'h008, 0);
    wr(12'h010, 1);
    wr(12'h004, 0);
    wr(12'h000, 32'h7);                      // match at E1, irq at E2
    repeat (3) @(negedge clk);
    check("mid_irq_before_rst", irq_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_irq_async", irq_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_ctrl",   12'h000, 0);
    rd_chk("post_rst_count",  12'h00C, 0);
    rd_chk("post_rst_status", 12'h010, 0);
    rd_chk("post_rst_cmp",    12'h008, 0);
    check("post_rst_irq", irq_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
